// File: rtl/aib_avmm_cfg_arbiter.sv
// aib_avmm_cfg_arbiter: round-robin arbiter sharing one AVMM config master among NUM_REQ requesters
//   clk, rst_n                 : clock, synchronous active-low reset
//   req_*_i / req_*_o          : per-requester AVMM slave ports (flattened, requester k in slice k)
//   avmm_*_o / avmm_*_i        : downstream AVMM master port
//   grant_o, busy_o            : one-hot current owner, transaction in flight
//   timeout_err_o, err_clr_i   : sticky timeout flag and its clear
module aib_avmm_cfg_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int AVMM_WIDTH  = 32,
  parameter int BYTE_WIDTH  = 4,
  parameter int ADDR_W      = 17,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_address_i,
  input  logic [NUM_REQ-1:0]            req_read_i,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*AVMM_WIDTH-1:0] req_writedata_i,
  input  logic [NUM_REQ*BYTE_WIDTH-1:0] req_byteenable_i,
  output logic [NUM_REQ-1:0]            req_waitrequest_o,
  output logic [NUM_REQ-1:0]            req_readdatavalid_o,
  output logic [AVMM_WIDTH-1:0]         req_readdata_o,
  output logic [ADDR_W-1:0]             avmm_address_o,
  output logic                          avmm_read_o,
  output logic                          avmm_write_o,
  output logic [AVMM_WIDTH-1:0]         avmm_writedata_o,
  output logic [BYTE_WIDTH-1:0]         avmm_byteenable_o,
  input  logic [AVMM_WIDTH-1:0]         avmm_readdata_i,
  input  logic                          avmm_readdatavalid_i,
  input  logic                          avmm_waitrequest_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          timeout_err_o,
  input  logic                          err_clr_i
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, CMD, RD_WAIT} state_t;
  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]       gidx_q, gidx_d, rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [NUM_REQ-1:0]  active;
  logic [IW-1:0]       idx, sel, next_ptr;
  logic                found, tmo, tmo_hit, g_rd, g_wr;
  assign grant_o          = grant_q;
  assign busy_o           = state_q != IDLE;
  assign timeout_err_o    = err_q;
  assign avmm_address_o   = req_address_i[gidx_q*ADDR_W +: ADDR_W];
  assign avmm_writedata_o = req_writedata_i[gidx_q*AVMM_WIDTH +: AVMM_WIDTH];
  assign avmm_byteenable_o = req_byteenable_i[gidx_q*BYTE_WIDTH +: BYTE_WIDTH];
  // Round-robin search starting at rr_ptr_q, first active requester wins.
  always_comb begin
    active = req_read_i | req_write_i;
    found  = 1'b0;
    sel    = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && active[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end
  always_comb begin
    g_rd     = req_read_i[gidx_q];
    g_wr     = req_write_i[gidx_q];
    next_ptr = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
    tmo_hit  = cnt_q == CW'(TIMEOUT_CYC - 1);
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q + 1'b1;
    tmo      = 1'b0;
    avmm_read_o         = 1'b0;
    avmm_write_o        = 1'b0;
    req_waitrequest_o   = '1;
    req_readdatavalid_o = '0;
    req_readdata_o      = avmm_readdata_i;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          state_d = CMD;
          grant_d = NUM_REQ'(1) << sel;
          gidx_d  = sel;
        end
      end
      CMD: begin
        if (!g_rd && !g_wr) begin
          // requester withdrew: abandon silently, keep its priority
          state_d = IDLE;
          grant_d = '0;
        end else if (tmo_hit) begin
          // abort: command dropped, requester released with a waitrequest pulse
          tmo = 1'b1;
          req_waitrequest_o[gidx_q] = 1'b0;
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end else begin
          avmm_write_o = g_wr;
          avmm_read_o  = !g_wr;
          if (!avmm_waitrequest_i) begin
            req_waitrequest_o[gidx_q] = 1'b0;
            if (g_wr) begin
              state_d  = IDLE;
              grant_d  = '0;
              rr_ptr_d = next_ptr;
            end else begin
              state_d = RD_WAIT;
              cnt_d   = '0;
            end
          end
        end
      end
      RD_WAIT: begin
        if (avmm_readdatavalid_i || tmo_hit) begin
          tmo = !avmm_readdatavalid_i;
          req_readdata_o = avmm_readdatavalid_i ? avmm_readdata_i : AVMM_WIDTH'(32'hDEAD_BEEF);
          req_readdatavalid_o[gidx_q] = 1'b1;
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    err_d = tmo ? 1'b1 : err_clr_i ? 1'b0 : err_q;
    // outputs held at reset values for the whole reset cycle, not just after the edge
    if (!rst_n) begin
      avmm_read_o         = 1'b0;
      avmm_write_o        = 1'b0;
      req_waitrequest_o   = '1;
      req_readdatavalid_o = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_aib_avmm_cfg_arbiter.sv
// tb_aib_avmm_cfg_arbiter: scoreboard bench for the AVMM config arbiter
module tb_aib_avmm_cfg_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [33:0] req_address_i;
  logic [1:0]  req_read_i, req_write_i;
  logic [63:0] req_writedata_i;
  logic [7:0]  req_byteenable_i;
  logic [1:0]  req_waitrequest_o, req_readdatavalid_o;
  logic [31:0] req_readdata_o;
  logic [16:0] avmm_address_o;
  logic        avmm_read_o, avmm_write_o;
  logic [31:0] avmm_writedata_o;
  logic [3:0]  avmm_byteenable_o;
  logic [31:0] avmm_readdata_i;
  logic        avmm_readdatavalid_i, avmm_waitrequest_i;
  logic [1:0]  grant_o;
  logic        busy_o, timeout_err_o, err_clr_i;
  int vec = 0;
  int miss = 0;
  typedef struct {logic [1:0] gnt; logic [16:0] addr; logic [31:0] data;} exp_t;
  exp_t sbq[$];
  exp_t e;

  always #5 clk = ~clk;

  aib_avmm_cfg_arbiter #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_address_i(req_address_i), .req_read_i(req_read_i), .req_write_i(req_write_i),
    .req_writedata_i(req_writedata_i), .req_byteenable_i(req_byteenable_i),
    .req_waitrequest_o(req_waitrequest_o), .req_readdatavalid_o(req_readdatavalid_o),
    .req_readdata_o(req_readdata_o),
    .avmm_address_o(avmm_address_o), .avmm_read_o(avmm_read_o), .avmm_write_o(avmm_write_o),
    .avmm_writedata_o(avmm_writedata_o), .avmm_byteenable_o(avmm_byteenable_o),
    .avmm_readdata_i(avmm_readdata_i), .avmm_readdatavalid_i(avmm_readdatavalid_i),
    .avmm_waitrequest_i(avmm_waitrequest_i),
    .grant_o(grant_o), .busy_o(busy_o), .timeout_err_o(timeout_err_o), .err_clr_i(err_clr_i)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_address_i = '0; req_read_i = '0; req_write_i = '0;
    req_writedata_i = '0; req_byteenable_i = '0;
    avmm_readdata_i = '0; avmm_readdatavalid_i = 1'b0; avmm_waitrequest_i = 1'b0;
    err_clr_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    sbq.delete();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int k, input logic rd, input logic wr,
                         input logic [16:0] a, input logic [31:0] d);
    req_read_i[k]  = rd;
    req_write_i[k] = wr;
    req_address_i[k*17 +: 17]   = a;
    req_writedata_i[k*32 +: 32] = d;
    req_byteenable_i[k*4 +: 4]  = 4'hF;
  endtask

  task automatic test_reset();
    idle_inputs();
    set_req(0, 1'b0, 1'b1, 17'h1, 32'h1);
    avmm_readdatavalid_i = 1'b1;
    rst_n = 1'b0;
    step();
    smp();
    vec++;
    if ({grant_o, busy_o, timeout_err_o} !== 4'b0000) begin
      miss++; $display("FAIL reset_status: got %b want 0000", {grant_o, busy_o, timeout_err_o});
    end
    vec++;
    if ({avmm_read_o, avmm_write_o, req_waitrequest_o, req_readdatavalid_o} !== 6'b00_11_00) begin
      miss++; $display("FAIL reset_outputs: got %b want 001100",
                       {avmm_read_o, avmm_write_o, req_waitrequest_o, req_readdatavalid_o});
    end
  endtask

  task automatic test_write();
    do_reset();
    set_req(0, 1'b0, 1'b1, 17'h00010, 32'hA5A5_0001);
    sbq.push_back('{2'b01, 17'h00010, 32'hA5A5_0001});
    smp();
    vec++;
    if ({grant_o, busy_o} !== 3'b000) begin
      miss++; $display("FAIL wr_cycleN: got %b want 000", {grant_o, busy_o});
    end
    step();
    smp();
    vec++;
    if ({avmm_write_o, avmm_read_o, req_waitrequest_o} !== 4'b1010) begin
      miss++; $display("FAIL wr_accept: got %b want 1010", {avmm_write_o, avmm_read_o, req_waitrequest_o});
    end
    if (avmm_write_o && !avmm_waitrequest_i && sbq.size() != 0) begin
      e = sbq.pop_front();
      vec++;
      if ({grant_o, avmm_address_o, avmm_writedata_o, avmm_byteenable_o} !== {e.gnt, e.addr, e.data, 4'hF}) begin
        miss++; $display("FAIL wr_data: got %h/%h/%h/%h want %h/%h/%h/f", grant_o, avmm_address_o,
                         avmm_writedata_o, avmm_byteenable_o, e.gnt, e.addr, e.data);
      end
    end
    vec++;
    if (sbq.size() != 0) begin
      miss++; $display("FAIL wr_sb: got %0d pending want 0", sbq.size());
    end
    step();
    req_write_i = '0;
    smp();
    vec++;
    if ({busy_o, grant_o, req_waitrequest_o} !== 5'b0_00_11) begin
      miss++; $display("FAIL wr_idle: got %b want 00011", {busy_o, grant_o, req_waitrequest_o});
    end
  endtask

  task automatic test_back_to_back();
    int done;
    do_reset();
    set_req(0, 1'b0, 1'b1, 17'h00100, 32'h1000_0000);
    set_req(1, 1'b0, 1'b1, 17'h00101, 32'h1000_0001);
    sbq.push_back('{2'b01, 17'h00100, 32'h1000_0000});
    sbq.push_back('{2'b10, 17'h00101, 32'h1000_0001});
    sbq.push_back('{2'b01, 17'h00100, 32'h1000_0000});
    sbq.push_back('{2'b10, 17'h00101, 32'h1000_0001});
    done = 0;
    for (int c = 0; c < 8; c++) begin
      smp();
      if (avmm_write_o && !avmm_waitrequest_i) begin
        done++;
        vec++;
        if (sbq.size() == 0) begin
          miss++; $display("FAIL b2b_extra: got write at cycle %0d want none", c);
        end else begin
          e = sbq.pop_front();
          if ({grant_o, req_waitrequest_o, avmm_address_o, avmm_writedata_o} !== {e.gnt, ~e.gnt, e.addr, e.data}) begin
            miss++; $display("FAIL b2b_write: got %b/%b/%h/%h want %b/%b/%h/%h", grant_o, req_waitrequest_o,
                             avmm_address_o, avmm_writedata_o, e.gnt, ~e.gnt, e.addr, e.data);
          end
        end
      end
      step();
    end
    req_write_i = '0;
    vec++;
    if (done != 4 || sbq.size() != 0) begin
      miss++; $display("FAIL b2b_rate: got %0d writes want 4", done);
    end
  endtask

  task automatic test_read();
    int pulses;
    do_reset();
    set_req(1, 1'b1, 1'b0, 17'h00200, 32'h0);
    sbq.push_back('{2'b10, 17'h00200, 32'h1234_5678});
    step();
    smp();
    vec++;
    if ({avmm_read_o, avmm_write_o, req_waitrequest_o, grant_o, avmm_address_o} !== {1'b1, 1'b0, 2'b01, 2'b10, 17'h00200}) begin
      miss++; $display("FAIL rd_cmd: got %b%b/%b/%b/%h want 10/01/10/00200", avmm_read_o, avmm_write_o,
                       req_waitrequest_o, grant_o, avmm_address_o);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      req_read_i = '0;
      avmm_readdatavalid_i = (i == 2 || i == 5);
      avmm_readdata_i = (i == 2) ? 32'h1234_5678 : 32'hBAD0_0000;
      smp();
      if (i == 0) begin
        vec++;
        if ({avmm_read_o, avmm_write_o, busy_o} !== 3'b001) begin
          miss++; $display("FAIL rd_wait: got %b want 001", {avmm_read_o, avmm_write_o, busy_o});
        end
      end
      if (req_readdatavalid_o !== 2'b00) begin
        pulses++;
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          vec++;
          if ({req_readdatavalid_o, req_readdata_o} !== {e.gnt, e.data}) begin
            miss++; $display("FAIL rd_data: got %b/%h want %b/%h", req_readdatavalid_o, req_readdata_o, e.gnt, e.data);
          end
        end
      end
    end
    avmm_readdatavalid_i = 1'b0;
    vec++;
    if (pulses != 1 || sbq.size() != 0) begin
      miss++; $display("FAIL rd_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_timeout_cmd();
    int at;
    do_reset();
    avmm_waitrequest_i = 1'b1;
    set_req(0, 1'b0, 1'b1, 17'h00033, 32'h33);
    at = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      smp();
      if (c == 1) begin
        vec++;
        if ({avmm_write_o, req_waitrequest_o} !== 3'b111) begin
          miss++; $display("FAIL to_cmd_hold: got %b want 111", {avmm_write_o, req_waitrequest_o});
        end
      end
      if (req_waitrequest_o[0] === 1'b0) begin
        at = c;
        vec++;
        if ({avmm_write_o, avmm_read_o} !== 2'b00) begin
          miss++; $display("FAIL to_cmd_drop: got %b want 00", {avmm_write_o, avmm_read_o});
        end
        break;
      end
    end
    step();
    req_write_i = '0;
    vec++;
    if (at != 8) begin
      miss++; $display("FAIL to_cmd_cycle: got %0d want 8", at);
    end
    smp();
    vec++;
    if ({timeout_err_o, busy_o} !== 2'b10) begin
      miss++; $display("FAIL to_cmd_err: got %b want 10", {timeout_err_o, busy_o});
    end
    step();
    step();
    smp();
    vec++;
    if (timeout_err_o !== 1'b1) begin
      miss++; $display("FAIL to_sticky: got %b want 1", timeout_err_o);
    end
    step();
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    smp();
    vec++;
    if (timeout_err_o !== 1'b0) begin
      miss++; $display("FAIL to_clear: got %b want 0", timeout_err_o);
    end
    avmm_waitrequest_i = 1'b0;
    set_req(0, 1'b0, 1'b1, 17'h1, 32'h1);
    set_req(1, 1'b0, 1'b1, 17'h2, 32'h2);
    step();
    smp();
    vec++;
    if (grant_o !== 2'b10) begin
      miss++; $display("FAIL to_rr_ptr: got %b want 10", grant_o);
    end
    step();
    req_write_i = '0;
  endtask

  task automatic test_timeout_rd();
    int pulses, at;
    do_reset();
    set_req(0, 1'b1, 1'b0, 17'h00044, 32'h0);
    sbq.push_back('{2'b01, 17'h00044, 32'hDEAD_BEEF});
    step();
    pulses = 0;
    at = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      req_read_i = '0;
      smp();
      if (req_readdatavalid_o !== 2'b00) begin
        pulses++;
        at = i;
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          vec++;
          if ({req_readdatavalid_o, req_readdata_o} !== {e.gnt, e.data}) begin
            miss++; $display("FAIL to_rd_data: got %b/%h want %b/%h", req_readdatavalid_o, req_readdata_o, e.gnt, e.data);
          end
        end
      end
    end
    vec++;
    if (pulses != 1 || at != 7) begin
      miss++; $display("FAIL to_rd_pulse: got %0d pulses at %0d want 1 at 7", pulses, at);
    end
    vec++;
    if ({timeout_err_o, busy_o} !== 2'b10) begin
      miss++; $display("FAIL to_rd_err: got %b want 10", {timeout_err_o, busy_o});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(1, 1'b1, 1'b0, 17'h00055, 32'h0);
    step();
    step();
    req_read_i = '0;
    smp();
    vec++;
    if (busy_o !== 1'b1) begin
      miss++; $display("FAIL rm_inflight: got %b want 1", busy_o);
    end
    step();
    rst_n = 1'b0;
    smp();
    vec++;
    if ({avmm_read_o, avmm_write_o, req_waitrequest_o, req_readdatavalid_o} !== 6'b00_11_00) begin
      miss++; $display("FAIL rm_during: got %b want 001100",
                       {avmm_read_o, avmm_write_o, req_waitrequest_o, req_readdatavalid_o});
    end
    step();
    rst_n = 1'b1;
    avmm_readdatavalid_i = 1'b1;
    avmm_readdata_i = 32'h0000_CAFE;
    for (int i = 0; i < 3; i++) begin
      smp();
      vec++;
      if ({grant_o, busy_o, timeout_err_o, avmm_read_o, avmm_write_o, req_waitrequest_o, req_readdatavalid_o} !== 10'b00_0_0_0_0_11_00) begin
        miss++; $display("FAIL rm_late_valid: got %b want 0000001100",
                         {grant_o, busy_o, timeout_err_o, avmm_read_o, avmm_write_o, req_waitrequest_o, req_readdatavalid_o});
      end
      step();
    end
    avmm_readdatavalid_i = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    avmm_waitrequest_i = 1'b1;
    set_req(0, 1'b0, 1'b1, 17'h00066, 32'h66);
    step();
    req_write_i = '0;
    smp();
    vec++;
    if ({avmm_write_o, req_waitrequest_o, busy_o} !== 4'b0_11_1) begin
      miss++; $display("FAIL drop_cmd: got %b want 0111", {avmm_write_o, req_waitrequest_o, busy_o});
    end
    step();
    smp();
    vec++;
    if ({busy_o, req_readdatavalid_o, req_waitrequest_o, timeout_err_o} !== 6'b0_00_11_0) begin
      miss++; $display("FAIL drop_idle: got %b want 000110", {busy_o, req_readdatavalid_o, req_waitrequest_o, timeout_err_o});
    end
    avmm_waitrequest_i = 1'b0;
    step();
    set_req(0, 1'b0, 1'b1, 17'h1, 32'h1);
    set_req(1, 1'b0, 1'b1, 17'h2, 32'h2);
    step();
    smp();
    vec++;
    if (grant_o !== 2'b01) begin
      miss++; $display("FAIL drop_rr_ptr: got %b want 01", grant_o);
    end
    step();
    req_write_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_write();
    test_back_to_back();
    test_read();
    test_timeout_cmd();
    test_timeout_rd();
    test_reset_mid();
    test_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
